// File: rtl/crc_pkg.sv
// Shared CRC engine types, standard polynomial presets and sizing helpers.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_APPEND = 2'd2
  } crc_state_e;

  // CRC-16/CCITT-FALSE
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;

  // CRC-8/ATM
  localparam logic [7:0]  CRC8_ATM_POLY    = 8'h07;
  localparam logic [7:0]  CRC8_ATM_INIT    = 8'h00;

  // CRC-32 (normal form, non-reflected register)
  localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFF_FFFF;

  // Number of output beats needed to carry one CRC value.
  function automatic int unsigned crc_beats(input int unsigned crc_w,
                                            input int unsigned data_w);
    return crc_w / data_w;
  endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Framed valid/ready stream pair: upstream payload in, downstream payload+CRC out.
interface crc_stream_engine_if #(
  parameter int unsigned DATA_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Source of input frames and sink of output frames.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The CRC engine.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/crc_next_comb.sv
// Combinational unrolled LFSR: advances a CRC register by one DATA_W-bit beat, MSB first.
module crc_next_comb #(
  parameter int unsigned             DATA_W = 8,
  parameter int unsigned             CRC_W  = 16,
  parameter logic [CRC_W-1:0]        POLY   = CRC_W'(16'h1021)
) (
  input  logic [CRC_W-1:0]  i_crc,
  input  logic [DATA_W-1:0] i_data,
  output logic [CRC_W-1:0]  o_crc_c
);

  logic [CRC_W-1:0] w_reg;
  logic             w_fb;

  // DATA_W serial shift steps, no reflection.
  always_comb begin
    w_reg = i_crc;
    w_fb  = 1'b0;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      w_fb  = w_reg[CRC_W-1] ^ i_data[i];
      w_reg = {w_reg[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
    o_crc_c = w_reg;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator (appends CRC) / checker (validates trailing CRC) with backpressure.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC16_CCITT_POLY),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(CRC16_CCITT_INIT),
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_mode,
  crc_stream_engine_if.slave  s_if,
  output logic [CRC_W-1:0]    o_crc_value,
  output logic                o_crc_done,
  output logic                o_crc_ok
);

  localparam int unsigned N_BEATS = crc_beats(CRC_W, DATA_W);
  localparam int unsigned IDX_W   = $clog2(N_BEATS + 1);

  // Reject widths where the CRC cannot be split into whole beats.
  if ((CRC_W % DATA_W) != 0) begin : g_bad_width
    $error("crc_stream_engine: CRC_W must be an integer multiple of DATA_W");
  end

  crc_state_e        r_state;
  crc_state_e        w_state_next;
  logic [CRC_W-1:0]  r_crc;
  logic              r_mode;
  logic [IDX_W-1:0]  r_idx;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [CRC_W-1:0]  r_crc_value;
  logic              r_crc_done;
  logic              r_crc_ok;

  logic              w_out_free;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_mode_eff;
  logic [CRC_W-1:0]  w_crc_cur;
  logic [CRC_W-1:0]  w_crc_upd;
  logic [CRC_W-1:0]  w_crc_fin;
  logic [DATA_W-1:0] w_slice;
  logic              w_app_load;
  logic              w_app_done;
  logic              w_chk_done;

  // Handshake and control strobes.
  assign w_out_free = ~r_out_valid | s_if.out_ready;
  assign w_in_ready = (r_state != ST_APPEND) & w_out_free;
  assign w_accept   = s_if.in_valid & w_in_ready;
  assign w_mode_eff = (r_state == ST_IDLE) ? i_mode : r_mode;
  assign w_crc_cur  = (r_state == ST_IDLE) ? INIT : r_crc;
  assign w_crc_fin  = r_crc ^ XOR_OUT;
  assign w_app_load = (r_state == ST_APPEND) & w_out_free & (r_idx != IDX_W'(N_BEATS));
  assign w_app_done = (r_state == ST_APPEND) & w_out_free & (r_idx == IDX_W'(N_BEATS));
  assign w_chk_done = w_accept & s_if.in_last & w_mode_eff;

  crc_next_comb #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY)
  ) u_next (
    .i_crc   (w_crc_cur),
    .i_data  (s_if.in_data),
    .o_crc_c (w_crc_upd)
  );

  // Select the CRC slice for the current append beat, most significant first.
  always_comb begin
    w_slice = '0;
    for (int unsigned k = 0; k < N_BEATS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_slice = w_crc_fin[CRC_W-1-k*DATA_W -: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DATA: begin
        if (w_accept) begin
          if (s_if.in_last) begin
            w_state_next = w_mode_eff ? ST_IDLE : ST_APPEND;
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end
      ST_APPEND: begin
        if (w_app_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // CRC register, output stage and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_crc       <= INIT;
      r_mode      <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_crc_value <= '0;
      r_crc_done  <= 1'b0;
      r_crc_ok    <= 1'b0;
    end else begin
      r_crc_done <= 1'b0;

      if (w_accept) begin
        r_mode      <= w_mode_eff;
        r_crc       <= w_chk_done ? INIT : w_crc_upd;
        r_out_valid <= 1'b1;
        r_out_data  <= s_if.in_data;
        r_out_last  <= w_mode_eff & s_if.in_last;
      end else if (w_app_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_slice;
        r_out_last  <= (r_idx == IDX_W'(N_BEATS - 1));
        r_idx       <= r_idx + IDX_W'(1);
      end else if (s_if.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_chk_done) begin
        r_crc_done  <= 1'b1;
        r_crc_ok    <= (w_crc_upd == RESIDUE);
        r_crc_value <= w_crc_upd ^ XOR_OUT;
      end

      if (w_app_done) begin
        r_crc_done  <= 1'b1;
        r_crc_value <= w_crc_fin;
        r_crc       <= INIT;
        r_idx       <= '0;
      end
    end
  end

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_data  = r_out_data;
  assign s_if.out_last  = r_out_last;
  assign o_crc_value    = r_crc_value;
  assign o_crc_done     = r_crc_done;
  assign o_crc_ok       = r_crc_ok;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench: CRC-16/CCITT-FALSE and CRC-8/ATM engines, generate and check modes.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       mode;
  logic       sel;
  logic       in_valid;
  logic       in_last;
  logic [7:0] in_data;
  logic       out_ready;
  logic       rand_ready;

  int tests = 0;
  int fails = 0;

  crc_stream_engine_if #(.DATA_W(8)) if_a ();
  crc_stream_engine_if #(.DATA_W(8)) if_b ();

  assign if_a.in_valid  = in_valid & ~sel;
  assign if_a.in_data   = in_data;
  assign if_a.in_last   = in_last;
  assign if_a.out_ready = out_ready;
  assign if_b.in_valid  = in_valid & sel;
  assign if_b.in_data   = in_data;
  assign if_b.in_last   = in_last;
  assign if_b.out_ready = out_ready;

  logic [15:0] crc_a;
  logic        done_a;
  logic        ok_a;
  logic [7:0]  crc_b;
  logic        done_b;
  logic        ok_b;

  crc_stream_engine dut_a (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mode      (mode),
    .s_if        (if_a),
    .o_crc_value (crc_a),
    .o_crc_done  (done_a),
    .o_crc_ok    (ok_a)
  );

  crc_stream_engine #(
    .DATA_W  (8),
    .CRC_W   (8),
    .POLY    (8'h07),
    .INIT    (8'h00),
    .XOR_OUT (8'h00),
    .RESIDUE (8'h00)
  ) dut_b (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mode      (mode),
    .s_if        (if_b),
    .o_crc_value (crc_b),
    .o_crc_done  (done_b),
    .o_crc_ok    (ok_b)
  );

  // Output beat collectors and done-pulse counters, sampled mid-cycle.
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  always @(negedge clk) begin
    if (if_a.out_valid && if_a.out_ready) qa.push_back({if_a.out_last, if_a.out_data});
    if (if_b.out_valid && if_b.out_ready) qb.push_back({if_b.out_last, if_b.out_data});
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic m);
    int   n   = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = m;
    while (!acc && n < 200) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = sel ? if_b.in_ready : if_a.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input logic m);
    for (int i = 0; i < bytes.size(); i++) begin
      send_beat(bytes[i], (i == bytes.size() - 1), m);
    end
  endtask

  task automatic wait_done(input string tag, output logic ready_at_done);
    int   n    = 0;
    logic seen = 1'b0;
    ready_at_done = 1'b0;
    while (!seen && n < 500) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (sel ? done_b : done_a) begin
        seen          = 1'b1;
        ready_at_done = sel ? if_b.in_ready : if_a.in_ready;
      end
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b1;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_done_width"}, 32'(sel ? done_b : done_a), 32'd0);
  endtask

  task automatic check_stream(input string tag, input logic [8:0] got[$], input logic [8:0] exp[$]);
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [7:0] msg[$];
    logic [7:0] frm[$];
    logic [8:0] exp_q[$];
    logic       rdy;
    int         d0;

    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    rst        = 1'b1;
    mode       = 1'b0;
    sel        = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b1;
    rand_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state.
    check("rst_out_valid", 32'(if_a.out_valid), 32'd0);
    check("rst_out_data",  32'(if_a.out_data),  32'd0);
    check("rst_out_last",  32'(if_a.out_last),  32'd0);
    check("rst_crc_value", 32'(crc_a),          32'd0);
    check("rst_crc_done",  32'(done_a),         32'd0);
    check("rst_crc_ok",    32'(ok_a),           32'd0);
    check("rst_in_ready",  32'(if_a.in_ready),  32'd1);

    // CRC-16/CCITT-FALSE generate over "123456789".
    qa.delete();
    d0 = done_cnt_a;
    send_frame(msg, 1'b0);
    wait_done("gen16", rdy);
    exp_q.delete();
    foreach (msg[i]) exp_q.push_back({1'b0, msg[i]});
    exp_q.push_back({1'b0, 8'h29});
    exp_q.push_back({1'b1, 8'hB1});
    check_stream("gen16", qa, exp_q);
    check("gen16_crc_value", 32'(crc_a), 32'h29B1);
    check("gen16_done_cnt", 32'(done_cnt_a - d0), 32'd1);
    check("gen16_ready_at_done", 32'(rdy), 32'd1);

    // CRC-8/ATM generate over the same payload.
    sel = 1'b1;
    qb.delete();
    d0 = done_cnt_b;
    send_frame(msg, 1'b0);
    wait_done("gen8", rdy);
    exp_q.delete();
    foreach (msg[i]) exp_q.push_back({1'b0, msg[i]});
    exp_q.push_back({1'b1, 8'hF4});
    check_stream("gen8", qb, exp_q);
    check("gen8_crc_value", 32'(crc_b), 32'hF4);
    check("gen8_done_cnt", 32'(done_cnt_b - d0), 32'd1);
    sel = 1'b0;

    // Check mode, good frame with trailing CRC.
    frm = msg;
    frm.push_back(8'h29);
    frm.push_back(8'hB1);
    qa.delete();
    send_frame(frm, 1'b1);
    wait_done("chk_good", rdy);
    exp_q.delete();
    foreach (frm[i]) exp_q.push_back({(i == frm.size() - 1), frm[i]});
    check_stream("chk_good", qa, exp_q);
    check("chk_good_ok", 32'(ok_a), 32'd1);
    check("chk_good_crc_value", 32'(crc_a), 32'h0000);

    // Check mode, corrupted payload byte.
    frm[4] = 8'h34;
    qa.delete();
    send_frame(frm, 1'b1);
    wait_done("chk_bad", rdy);
    check("chk_bad_ok", 32'(ok_a), 32'd0);
    check("chk_bad_len", 32'(qa.size()), 32'd11);

    // Generate under random downstream backpressure.
    rand_ready = 1'b1;
    qa.delete();
    send_frame(msg, 1'b0);
    wait_done("bp", rdy);
    rand_ready = 1'b0;
    exp_q.delete();
    foreach (msg[i]) exp_q.push_back({1'b0, msg[i]});
    exp_q.push_back({1'b0, 8'h29});
    exp_q.push_back({1'b1, 8'hB1});
    check_stream("bp", qa, exp_q);
    check("bp_crc_value", 32'(crc_a), 32'h29B1);

    // Reset mid-frame, then a full frame.
    d0 = done_cnt_a;
    for (int i = 0; i < 4; i++) send_beat(msg[i], 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("abort_done_cnt", 32'(done_cnt_a - d0), 32'd0);
    check("abort_crc_value", 32'(crc_a), 32'd0);
    check("abort_out_valid", 32'(if_a.out_valid), 32'd0);
    qa.delete();
    send_frame(msg, 1'b0);
    wait_done("after_abort", rdy);
    check_stream("after_abort", qa, exp_q);
    check("after_abort_crc_value", 32'(crc_a), 32'h29B1);
    check("after_abort_done_cnt", 32'(done_cnt_a - d0), 32'd1);

    // Single-beat frame 0x00, then a back-to-back repeat.
    frm.delete();
    frm.push_back(8'h00);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hE1});
    exp_q.push_back({1'b1, 8'hF0});
    qa.delete();
    send_frame(frm, 1'b0);
    wait_done("single", rdy);
    check_stream("single", qa, exp_q);
    check("single_crc_value", 32'(crc_a), 32'hE1F0);
    check("single_ready_at_done", 32'(rdy), 32'd1);
    qa.delete();
    send_frame(frm, 1'b0);
    wait_done("single2", rdy);
    check_stream("single2", qa, exp_q);
    check("single2_crc_value", 32'(crc_a), 32'hE1F0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
